difftest_commit_ctrl: RTL

Sequencer that sits between the NPC core's commit/writeback stage and the `DiffTestSignal` DPI bridge. It accepts one retired-instruction event at a time and waits a configurable number of cycles for the register file and CSR writes to land. It then fires exactly one report pulse, either a compare (`ds_enable`) or a skip (`ds_skip`, used for MMIO-touching instructions), holding it under host backpressure. It also keeps retirement and skip counters, and drains cleanly on halt so the simulator never compares a half-written architectural state.

---
 rtl/difftest_pkg.sv | 14 +
 rtl/difftest_commit_ctrl_if.sv | 32 +++
 rtl/difftest_commit_ctrl_sat_counter.sv | 23 ++
 rtl/difftest_commit_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit sequencer: controller states and the
// architectural register width.
package difftest_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/difftest_commit_ctrl_if.sv
// Commit-side and host-side signal bundle for difftest_commit_ctrl.
// master = core/host environment, slave = the controller.
interface difftest_commit_ctrl_if #(
    parameter int CNT_W = 32
) ();
    import difftest_pkg::*;

    logic            cfg_en;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            commit_skip;
    logic            commit_ready;
    logic            halt;
    logic            host_ready;
    logic            ds_enable;
    logic            ds_skip;
    logic [XLEN-1:0] ds_pc;
    logic [CNT_W-1:0] commit_cnt;
    logic [15:0]     skip_cnt;
    logic            done;

    modport master (
        output cfg_en, commit_valid, commit_pc, commit_skip, halt, host_ready,
        input  commit_ready, ds_enable, ds_skip, ds_pc, commit_cnt, skip_cnt, done
    );

    modport slave (
        input  cfg_en, commit_valid, commit_pc, commit_skip, halt, host_ready,
        output commit_ready, ds_enable, ds_skip, ds_pc, commit_cnt, skip_cnt, done
    );

endinterface

// File: rtl/difftest_commit_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc && !(&count_q)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/difftest_commit_ctrl.sv
// Sequences one retired instruction at a time from commit, through a settle
// delay, to a single compare/skip report for the DiffTest DPI bridge.
module difftest_commit_ctrl
    import difftest_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    difftest_commit_ctrl_if.slave bus
);

    localparam logic [3:0] SETTLE_INIT =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      settle_q, settle_d;
    logic            halt_pend_q, halt_pend_d;
    logic            skip_q, skip_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            enable_q, skip_strobe_q, done_q;

    logic            halt_now;
    logic            commit_ready;
    logic            accept;
    logic            start;
    logic            handshake;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            settle_q      <= '0;
            halt_pend_q   <= 1'b0;
            skip_q        <= 1'b0;
            pc_q          <= '0;
            enable_q      <= 1'b0;
            skip_strobe_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            halt_pend_q   <= halt_pend_d;
            skip_q        <= skip_d;
            pc_q          <= pc_d;
            enable_q      <= (state_d == REPORT) && !skip_d;
            skip_strobe_q <= (state_d == REPORT) && skip_d;
            done_q        <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        halt_pend_d = halt_pend_q | bus.halt;
        skip_d      = skip_q;
        pc_d        = pc_q;
        start       = 1'b0;

        // A halt seen in the handshake cycle itself must already block the
        // back-to-back accept, so the raw halt input joins the pending flag.
        halt_now     = halt_pend_q | bus.halt;
        handshake    = (state_q == REPORT) && bus.host_ready;
        commit_ready = (state_q == IDLE) || (handshake && !halt_now);
        accept       = bus.commit_valid && commit_ready;

        unique case (state_q)
            IDLE: begin
                if (accept && bus.cfg_en) begin
                    start = 1'b1;
                end else if (halt_now) begin
                    state_d = DONE;
                end
            end
            SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = REPORT;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            REPORT: begin
                if (bus.host_ready) begin
                    if (halt_now) begin
                        state_d = DONE;
                    end else if (accept && bus.cfg_en) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            pc_d   = bus.commit_pc;
            skip_d = bus.commit_skip;
            if (SETTLE_CYCLES == 0) begin
                state_d = REPORT;
            end else begin
                state_d  = SETTLE;
                settle_d = SETTLE_INIT;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_commit_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (handshake),
        .count (bus.commit_cnt)
    );

    sat_counter #(.W(16)) u_skip_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (handshake && skip_q),
        .count (bus.skip_cnt)
    );

    assign bus.commit_ready = commit_ready;
    assign bus.ds_enable    = enable_q;
    assign bus.ds_skip      = skip_strobe_q;
    assign bus.ds_pc        = pc_q;
    assign bus.done         = done_q;

endmodule
